// File: rtl/div_issue_seq_if.sv
// Job request, pipelined-divider and result bundle for div_issue_seq.
// The sequencer connects through the slave modport; the driver side uses master.
interface div_issue_seq_if #(
   parameter int COUNT = 8
);
   logic                  i_start;
   logic [21:0]           i_denominator;
   logic [COUNT*32-1:0]   i_numerators;
   logic [31:0]           o_divNumer;
   logic [21:0]           o_divDenom;
   logic [19:0]           i_divQuot;
   logic [COUNT*20-1:0]   o_results;
   logic                  o_busy;
   logic                  o_done;

   modport slave (
      input  i_start, i_denominator, i_numerators, i_divQuot,
      output o_divNumer, o_divDenom, o_results, o_busy, o_done
   );

   modport master (
      output i_start, i_denominator, i_numerators, i_divQuot,
      input  o_divNumer, o_divDenom, o_results, o_busy, o_done
   );
endinterface

// File: rtl/div_issue_seq.sv
// Issues COUNT numerators against one denominator to an external pipelined divider
// and collects the tagged quotients. Optional macro DIV_ZERO_GUARD_EN short-cuts zero denominators.
module div_issue_seq #(
   parameter int COUNT   = 8,
   parameter int LATENCY = 6
) (
   input logic            clock,
   input logic            reset,
   div_issue_seq_if.slave bus
);
   localparam int TAG_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(COUNT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t            state_reg;
   state_t            state_next;

   logic [31:0]       num_in [COUNT];
   logic [31:0]       num_reg [COUNT];
   logic [TAG_W-1:0]  index_reg;
   logic [31:0]       div_numer_reg;
   logic [21:0]       div_denom_reg;
   logic              pipe_valid_reg [LATENCY];
   logic [TAG_W-1:0]  pipe_tag_reg [LATENCY];
   logic [19:0]       res_reg [COUNT];

   logic              start_ok;
   logic              zero_den;
   logic              issue_last;
   logic              capture;
   logic              capture_last;
   logic              push_valid;
   logic [TAG_W-1:0]  push_tag;
   logic [31:0]       next_numer;
   logic              busy;
   logic              done;
   logic [COUNT*20-1:0] results_flat;

   for (genvar gi = 0; gi < COUNT; gi++) begin : g_slot
      assign num_in[gi] = bus.i_numerators[gi*32 +: 32];
   end

   assign start_ok = (state_reg == IDLE) && bus.i_start;

`ifdef DIV_ZERO_GUARD_EN
   assign zero_den = (bus.i_denominator == '0);
`else
   assign zero_den = 1'b0;
`endif

   assign issue_last   = (index_reg == LAST_TAG);
   assign capture      = pipe_valid_reg[LATENCY-1];
   assign capture_last = capture && (pipe_tag_reg[LATENCY-1] == LAST_TAG);

   // Pipe entry 0 always describes the operand currently on the divider inputs.
   always_comb begin
      push_valid = 1'b0;
      push_tag   = '0;
      if (start_ok && !zero_den) begin
         push_valid = 1'b1;
      end else if (state_reg == ISSUE && !issue_last) begin
         push_valid = 1'b1;
         push_tag   = index_reg + 1'b1;
      end
   end

   always_comb begin
      next_numer = num_reg[0];
      for (int k = 0; k < COUNT; k++) begin
         if (TAG_W'(k) == index_reg + 1'b1) next_numer = num_reg[k];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (bus.i_start) state_next = zero_den ? DONE : ISSUE;
         end
         ISSUE: begin
            // With LATENCY=1 the last quotient lands while still issuing.
            if (capture_last)    state_next = DONE;
            else if (issue_last) state_next = DRAIN;
         end
         DRAIN: begin
            if (capture_last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         index_reg     <= '0;
         div_numer_reg <= '0;
         div_denom_reg <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            pipe_valid_reg[k] <= 1'b0;
            pipe_tag_reg[k]   <= '0;
         end
         for (int k = 0; k < COUNT; k++) res_reg[k] <= '0;
      end else begin
         pipe_valid_reg[0] <= push_valid;
         pipe_tag_reg[0]   <= push_tag;
         for (int k = 1; k < LATENCY; k++) begin
            pipe_valid_reg[k] <= pipe_valid_reg[k-1];
            pipe_tag_reg[k]   <= pipe_tag_reg[k-1];
         end

         if (start_ok) begin
            for (int k = 0; k < COUNT; k++) num_reg[k] <= num_in[k];
            index_reg <= '0;
            if (!zero_den) begin
               div_numer_reg <= num_in[0];
               div_denom_reg <= bus.i_denominator;
            end
         end else if (state_reg == ISSUE && !issue_last) begin
            index_reg     <= index_reg + 1'b1;
            div_numer_reg <= next_numer;
         end

         if (start_ok && zero_den) begin
            for (int k = 0; k < COUNT; k++) res_reg[k] <= '0;
         end else if (capture) begin
            for (int k = 0; k < COUNT; k++) begin
               if (pipe_tag_reg[LATENCY-1] == TAG_W'(k)) res_reg[k] <= bus.i_divQuot;
            end
         end
      end
   end

   always_comb begin
      results_flat = '0;
      for (int k = 0; k < COUNT; k++) results_flat[k*20 +: 20] = res_reg[k];
   end

   assign bus.o_results  = results_flat;
   assign bus.o_divNumer = div_numer_reg;
   assign bus.o_divDenom = div_denom_reg;
   assign bus.o_busy     = busy;
   assign bus.o_done     = done;
endmodule
